// File: rtl/calc_time_sched.sv
// rtl/calc_time_sched.sv - five-axis sequencer sharing one calc_time core
// Optional WAIT_FIN watchdog: define CALC_SCHED_TIMEOUT_EN.
module calc_time_sched #(
    parameter logic [15:0] GAP_CYCLES     = 16'd20,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  axis_en,
    input  logic [31:0] params_x  [0:4],
    input  logic [31:0] params_y  [0:4],
    input  logic [31:0] params_z  [0:4],
    input  logic [31:0] params_e0 [0:4],
    input  logic [31:0] params_e1 [0:4],
    output logic        ct_start,
    output logic [31:0] ct_params [0:4],
    input  logic [63:0] ct_timing [0:3],
    input  logic        ct_finish,
    output logic [63:0] timing_x  [0:3],
    output logic [63:0] timing_y  [0:3],
    output logic [63:0] timing_z  [0:3],
    output logic [63:0] timing_e0 [0:3],
    output logic [63:0] timing_e1 [0:3],
    output logic [4:0]  done_mask,
    output logic        busy,
    output logic        finish,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_FIN, S_CAPTURE, S_RELEASE, S_GAP, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  pending;
    logic [2:0]  sel;
    logic [2:0]  issue_sel;
    logic [15:0] gap_cnt;
    logic        gap_last;
    logic        timeout_hit;

`ifdef CALC_SCHED_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;

    assign timeout_hit = (state == S_WAIT_FIN) && start && !ct_finish &&
                         (to_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
            to_cnt <= (state == S_WAIT_FIN) ? to_cnt + 16'd1 : 16'd0;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    // Fixed priority: lowest pending axis (X) wins.
    always_comb begin
        issue_sel = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (pending[i]) issue_sel = 3'(i);
    end

    assign gap_last = (gap_cnt == GAP_CYCLES - 16'd1);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign finish   = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!start)              state_nxt = S_RELEASE;
                else if (pending == '0)  state_nxt = S_DONE;
                else                     state_nxt = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (!start)              state_nxt = S_RELEASE;
                else if (ct_finish)      state_nxt = S_CAPTURE;
                else if (timeout_hit)    state_nxt = S_RELEASE;
            end
            S_CAPTURE:  state_nxt = S_RELEASE;
            S_RELEASE: begin
                if (!ct_finish) begin
                    if (!start)                  state_nxt = S_IDLE;
                    else if (pending == '0)      state_nxt = S_DONE;
                    else if (GAP_CYCLES == '0)   state_nxt = S_ISSUE;
                    else                         state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (!start)         state_nxt = S_RELEASE;
                else if (gap_last)  state_nxt = S_ISSUE;
            end
            S_DONE:     if (!start) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // The result write happens on the edge that sees ct_finish, so the
    // timing output and done bit are visible while CAPTURE is the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= '0;
            done_mask <= '0;
            sel       <= '0;
            gap_cnt   <= '0;
            ct_start  <= 1'b0;
            ct_params <= '{default: '0};
            timing_x  <= '{default: '0};
            timing_y  <= '{default: '0};
            timing_z  <= '{default: '0};
            timing_e0 <= '{default: '0};
            timing_e1 <= '{default: '0};
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending   <= axis_en;
                        done_mask <= '0;
                    end
                end
                S_ISSUE: begin
                    if (start && pending != '0) begin
                        sel      <= issue_sel;
                        ct_start <= 1'b1;
                        case (issue_sel)
                            3'd0:    ct_params <= params_x;
                            3'd1:    ct_params <= params_y;
                            3'd2:    ct_params <= params_z;
                            3'd3:    ct_params <= params_e0;
                            default: ct_params <= params_e1;
                        endcase
                    end
                end
                S_WAIT_FIN: begin
                    if (!start) begin
                        ct_start <= 1'b0;
                    end else if (ct_finish || timeout_hit) begin
                        ct_start       <= 1'b0;
                        pending[sel]   <= 1'b0;
                        done_mask[sel] <= 1'b1;
                        if (ct_finish) begin
                            case (sel)
                                3'd0:    timing_x  <= ct_timing;
                                3'd1:    timing_y  <= ct_timing;
                                3'd2:    timing_z  <= ct_timing;
                                3'd3:    timing_e0 <= ct_timing;
                                default: timing_e1 <= ct_timing;
                            endcase
                        end
                    end
                end
                S_RELEASE: gap_cnt <= '0;
                S_GAP:     gap_cnt <= gap_cnt + 16'd1;
                S_DONE:    if (!start) done_mask <= '0;
                default: ;
            endcase
        end
    end

endmodule
